// File: rtl/bp_me_pkg.sv
// Shared types and helpers for the mem-network wormhole tx serializer and rx deserializer.
package bp_me_pkg;

    localparam int unsigned bp_me_wh_flit_width_gp = 64;
    localparam int unsigned bp_me_wh_cord_width_gp = 7;
    localparam int unsigned bp_me_wh_len_width_gp  = 4;

    typedef enum logic {
        e_ready,
        e_send
    } bp_me_wh_tx_state_e;

    typedef struct packed {
        logic [bp_me_wh_flit_width_gp-bp_me_wh_cord_width_gp-bp_me_wh_len_width_gp-1:0] rest;
        logic [bp_me_wh_len_width_gp-1:0]  len;
        logic [bp_me_wh_cord_width_gp-1:0] cord;
    } bp_me_wh_flit0_s;

    // Flits needed for a packet with hdr_bits of routing/header and 2^size payload bytes.
    function automatic int unsigned bp_me_wh_num_flits(input logic [2:0] size,
                                                       input int unsigned hdr_bits,
                                                       input int unsigned flit_width);
        int unsigned bits;
        bits = hdr_bits + (32'd8 << size);
        return (bits + flit_width - 1) / flit_width;
    endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear together with up yields 1.
module bsg_counter_clear_up #(
    parameter int unsigned max_val_p  = 8,
    parameter int unsigned init_val_p = 0,
    localparam int unsigned ptr_width_lp = (max_val_p > 0) ? $clog2(max_val_p + 1) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    up_i,
    output logic [ptr_width_lp-1:0] count_o
);

    logic [ptr_width_lp-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            count_q <= ptr_width_lp'(init_val_p);
        else if (clear_i)
            count_q <= ptr_width_lp'(up_i);
        else if (up_i)
            count_q <= count_q + 1'b1;
    end

    assign count_o = count_q;

endmodule

// File: rtl/bp_me_wormhole_packet_tx.sv
// Serializes {data, hdr, len, cord} into wormhole flits, LSB flit first, one packet in flight.
// Define BP_ME_WH_TX_PIPELINE_EN to accept the next packet on the final-flit cycle (no bubble).
module bp_me_wormhole_packet_tx
    import bp_me_pkg::*;
#(
    parameter int unsigned flit_width_p    = 64,
    parameter int unsigned cord_width_p    = 7,
    parameter int unsigned len_width_p     = 4,
    parameter int unsigned hdr_width_p     = 53,
    parameter int unsigned payload_width_p = 512
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    output logic                       ready_o,
    input  logic [cord_width_p-1:0]    cord_i,
    input  logic [hdr_width_p-1:0]     hdr_i,
    input  logic [2:0]                 size_i,
    input  logic [payload_width_p-1:0] data_i,
    output logic                       link_v_o,
    output logic [flit_width_p-1:0]    link_data_o,
    input  logic                       link_ready_i
);

    localparam int unsigned route_width_lp  = cord_width_p + len_width_p + hdr_width_p;
    localparam int unsigned stream_width_lp = route_width_lp + payload_width_p;
    localparam int unsigned max_flits_lp    = (stream_width_lp + flit_width_p - 1) / flit_width_p;
    localparam int unsigned buf_width_lp    = max_flits_lp * flit_width_p;
    localparam int unsigned cnt_width_lp    = (max_flits_lp > 1) ? $clog2(max_flits_lp) : 1;

    if ((max_flits_lp - 1) >= (1 << len_width_p) || (cord_width_p + len_width_p) > flit_width_p) begin : g_bad_cfg
        $error("bp_me_wormhole_packet_tx: len field too narrow or cord+len wider than a flit");
    end

    bp_me_wh_tx_state_e state_q, state_d;

    logic [max_flits_lp-1:0][flit_width_p-1:0] stream_q, stream_d;
    logic [len_width_p-1:0]     len_q, len_d;
    logic [cnt_width_lp-1:0]    cnt;
    logic [payload_width_p-1:0] data_mask;
    logic [31:0]                payload_bits;
    logic ready_raw, link_v_raw, accept, xfer, last_flit, last_xfer;

    always_comb begin
        payload_bits = 32'd8 << size_i;
        data_mask    = '1;
        if (payload_bits < payload_width_p)
            data_mask = ~({payload_width_p{1'b1}} << payload_bits);
        len_d    = len_width_p'(bp_me_wh_num_flits(size_i, route_width_lp, flit_width_p) - 1);
        stream_d = buf_width_lp'({data_i & data_mask, hdr_i, len_d, cord_i});
    end

    always_comb begin
        state_d    = state_q;
        ready_raw  = 1'b0;
        link_v_raw = 1'b0;
        unique case (state_q)
            e_ready: begin
                ready_raw = 1'b1;
                if (v_i)
                    state_d = e_send;
            end
            e_send: begin
                link_v_raw = 1'b1;
                if (link_ready_i && last_flit) begin
                    state_d = e_ready;
`ifdef BP_ME_WH_TX_PIPELINE_EN
                    ready_raw = 1'b1;
                    if (v_i)
                        state_d = e_send;
`endif
                end
            end
            default: state_d = e_ready;
        endcase
    end

    // Outputs are gated by reset so the router never sees a stray flit while both reset.
    assign ready_o     = ready_raw & ~reset_i;
    assign link_v_o    = link_v_raw & ~reset_i;
    assign accept      = v_i & ready_o;
    assign xfer        = link_v_o & link_ready_i;
    assign last_flit   = (len_width_p'(cnt) == len_q);
    assign last_xfer   = xfer & last_flit;
    assign link_data_o = stream_q[cnt];

    bsg_counter_clear_up #(
        .max_val_p  (max_flits_lp - 1),
        .init_val_p (0)
    ) flit_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (accept | last_xfer),
        .up_i    (xfer & ~last_flit),
        .count_o (cnt)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i)
            state_q <= e_ready;
        else
            state_q <= state_d;
        if (accept) begin
            stream_q <= stream_d;
            len_q    <= len_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && accept)
            assert (size_i <= 3'd6 && (32'd8 << size_i) <= payload_width_p)
            else $error("bp_me_wormhole_packet_tx: illegal size_i %0d", size_i);
    end

endmodule

// File: tb/tb_bp_me_wormhole_packet_tx.sv
// Directed bench for bp_me_wormhole_packet_tx; honours BP_ME_WH_TX_PIPELINE_EN for back-to-back timing.
module tb_bp_me_wormhole_packet_tx;
    import bp_me_pkg::*;

    logic         clk = 1'b0;
    logic         reset_i, v_i, ready_o, link_v_o, link_ready_i;
    logic [6:0]   cord_i;
    logic [52:0]  hdr_i;
    logic [2:0]   size_i;
    logic [511:0] data_i;
    logic [63:0]  link_data_o;

    int tests = 0;
    int failed = 0;
    logic [63:0] got [16];
    int last_cycles;

    always #5 clk = ~clk;

    bp_me_wormhole_packet_tx #(
        .flit_width_p    (64),
        .cord_width_p    (7),
        .len_width_p     (4),
        .hdr_width_p     (53),
        .payload_width_p (512)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .cord_i       (cord_i),
        .hdr_i        (hdr_i),
        .size_i       (size_i),
        .data_i       (data_i),
        .link_v_o     (link_v_o),
        .link_data_o  (link_data_o),
        .link_ready_i (link_ready_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nflits(input logic [2:0] sz);
        return (64 + (8 << sz) + 63) / 64;
    endfunction

    function automatic logic [575:0] build_stream(input logic [6:0] cord, input logic [52:0] hdr,
                                                  input logic [2:0] sz, input logic [511:0] data);
        logic [575:0] es;
        es = '0;
        es[6:0]   = cord;
        es[10:7]  = 4'(nflits(sz) - 1);
        es[63:11] = hdr;
        for (int b = 0; b < (1 << sz); b++)
            es[64 + 8*b +: 8] = data[8*b +: 8];
        return es;
    endfunction

    task automatic load(input logic [6:0] cord, input logic [52:0] hdr,
                        input logic [2:0] sz, input logic [511:0] data);
        cord_i = cord; hdr_i = hdr; size_i = sz; data_i = data;
    endtask

    task automatic run_pkt(input logic [6:0] cord, input logic [52:0] hdr, input logic [2:0] sz,
                           input logic [511:0] data, input bit rnd, input string tag);
        logic [575:0] es;
        logic [63:0]  prev;
        int n, k, cyc;
        bit stalled;
        es = build_stream(cord, hdr, sz, data);
        n = nflits(sz);
        @(posedge clk); #1;
        load(cord, hdr, sz, data);
        v_i = 1'b1;
        #1;
        chk({tag, " accept_ready"}, 64'(ready_o), 64'd1);
        k = 0; cyc = 0; stalled = 1'b0; prev = '0;
        while (k < n && cyc < 200) begin
            @(posedge clk); #1;
            v_i = 1'b0;
            link_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            cyc++;
            chk({tag, " link_v"}, 64'(link_v_o), 64'd1);
`ifdef BP_ME_WH_TX_PIPELINE_EN
            chk({tag, " ready_busy"}, 64'(ready_o), 64'(k == n - 1 && link_ready_i));
`else
            chk({tag, " ready_busy"}, 64'(ready_o), 64'd0);
`endif
            if (stalled)
                chk({tag, " stall_stable"}, link_data_o, prev);
            if (link_ready_i) begin
                chk({tag, " flit"}, link_data_o, es[k*64 +: 64]);
                got[k] = link_data_o;
                k++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                prev = link_data_o;
            end
        end
        chk({tag, " flits_done"}, 64'(k), 64'(n));
        last_cycles = cyc;
        @(posedge clk); #1;
        link_ready_i = 1'b1;
        #1;
        chk({tag, " idle_v"}, 64'(link_v_o), 64'd0);
        chk({tag, " idle_ready"}, 64'(ready_o), 64'd1);
    endtask

    initial begin
        bp_me_wh_flit0_s f0;
        logic [511:0] d;
        logic [575:0] es_a, es_b;
        logic [5:0]   pat;
        bit           pend;
        int           nf;

        reset_i = 1'b1; v_i = 1'b0; link_ready_i = 1'b0;
        load('0, '0, '0, '0);

        // Reset state
        @(posedge clk); #1; #1;
        chk("rst ready", 64'(ready_o), 64'd0);
        chk("rst link_v", 64'(link_v_o), 64'd0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        #1;
        chk("post_rst ready", 64'(ready_o), 64'd1);
        chk("post_rst link_v", 64'(link_v_o), 64'd0);

        // 1: 8-byte payload, two flits
        d = '0;
        d[63:0] = 64'hDEAD_BEEF_0123_4567;
        run_pkt(7'h05, 53'h1_2345_6789_ABCD, 3'd3, d, 1'b0, "t1");
        f0 = got[0];
        chk("t1 cord", 64'(f0.cord), 64'h05);
        chk("t1 len", 64'(f0.len), 64'd1);
        chk("t1 hdr", 64'(f0.rest), 64'h1_2345_6789_ABCD);
        chk("t1 flit1", got[1], 64'hDEAD_BEEF_0123_4567);
        chk("t1 cycles", 64'(last_cycles), 64'd2);

        // 2: 64-byte payload, nine flits
        for (int k = 0; k < 8; k++)
            d[k*64 +: 64] = 64'h1111_1111_1111_1111 * 64'(k + 1);
        run_pkt(7'h7F, 53'h0, 3'd6, d, 1'b0, "t2");
        f0 = got[0];
        chk("t2 len", 64'(f0.len), 64'd8);
        chk("t2 cord", 64'(f0.cord), 64'h7F);
        chk("t2 flit1", got[1], 64'h1111_1111_1111_1111);
        chk("t2 flit8", got[8], 64'h8888_8888_8888_8888);
        chk("t2 cycles", 64'(last_cycles), 64'd9);

        // 3: single byte payload
        d = '0;
        d[7:0] = 8'hAB;
        run_pkt(7'h12, 53'h1F_FFFF_FFFF_FFFF, 3'd0, d, 1'b0, "t3");
        f0 = got[0];
        chk("t3 len", 64'(f0.len), 64'd1);
        chk("t3 flit1", got[1], 64'h0000_0000_0000_00AB);

        // 4: random link back-pressure on a full packet
        for (int k = 0; k < 16; k++)
            d[k*32 +: 32] = $urandom;
        run_pkt(7'h2A, 53'h0_0ACE_0000_BEEF, 3'd6, d, 1'b1, "t4");

        // 5: back-to-back two-flit packets
        d = '0;
        d[63:0] = 64'hA0A0_A0A0_A0A0_A0A1;
        es_a = build_stream(7'h01, 53'h111, 3'd3, d);
        @(posedge clk); #1;
        load(7'h01, 53'h111, 3'd3, d);
        v_i = 1'b1; link_ready_i = 1'b1;
        #1;
        chk("t5 accept_a", 64'(ready_o), 64'd1);
        d[63:0] = 64'hB0B0_B0B0_B0B0_B0B2;
        es_b = build_stream(7'h02, 53'h222, 3'd3, d);
        pend = 1'b1; pat = '0; nf = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (pend) begin
                load(7'h02, 53'h222, 3'd3, d);
                v_i = 1'b1;
            end else begin
                v_i = 1'b0;
            end
            link_ready_i = 1'b1;
            #1;
            pat[c] = link_v_o;
            if (link_v_o && nf < 4) begin
                got[nf] = link_data_o;
                nf++;
            end
            if (v_i && ready_o)
                pend = 1'b0;
        end
        v_i = 1'b0;
`ifdef BP_ME_WH_TX_PIPELINE_EN
        chk("t5 valid_pattern", 64'(pat), 64'b001111);
`else
        chk("t5 valid_pattern", 64'(pat), 64'b011011);
`endif
        chk("t5 a0", got[0], es_a[63:0]);
        chk("t5 a1", got[1], es_a[127:64]);
        chk("t5 b0", got[2], es_b[63:0]);
        chk("t5 b1", got[3], es_b[127:64]);

        // 6: reset after flit 3 of a nine-flit packet
        for (int k = 0; k < 8; k++)
            d[k*64 +: 64] = 64'hC000_0000_0000_0000 | 64'(k);
        es_a = build_stream(7'h44, 53'h5555, 3'd6, d);
        @(posedge clk); #1;
        load(7'h44, 53'h5555, 3'd6, d);
        v_i = 1'b1;
        #1;
        chk("t6 accept", 64'(ready_o), 64'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            v_i = 1'b0; link_ready_i = 1'b1;
            #1;
            chk("t6 link_v", 64'(link_v_o), 64'd1);
            chk("t6 flit", link_data_o, es_a[k*64 +: 64]);
        end
        @(posedge clk); #1;
        reset_i = 1'b1; link_ready_i = 1'b0;
        #1;
        chk("t6 rst link_v", 64'(link_v_o), 64'd0);
        chk("t6 rst ready", 64'(ready_o), 64'd0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        #1;
        chk("t6 rel ready", 64'(ready_o), 64'd1);
        chk("t6 rel link_v", 64'(link_v_o), 64'd0);
        d = '0;
        d[63:0] = 64'h0F0F_0F0F_0F0F_0F0F;
        run_pkt(7'h33, 53'h77, 3'd3, d, 1'b0, "t6n");
        f0 = got[0];
        chk("t6n len", 64'(f0.len), 64'd1);
        chk("t6n cord", 64'(f0.cord), 64'h33);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
